// File: rtl/rf_wr_sched_if.sv
// Write-scheduler bundle: requester handshakes, clear request and the register-file write port.
interface rf_wr_sched_if #(
    parameter int pw   = 2,
    parameter int NREQ = 3,
    parameter int DW   = 8
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*(pw+1)-1:0]   req_addr;
    logic [NREQ*DW-1:0]       req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     rf_wr_en;
    logic [pw:0]              rf_wr_addr;
    logic [DW-1:0]            rf_dat_in;
    logic [$clog2(NREQ)-1:0]  grant_id;

    modport master (
        output req_valid, req_addr, req_data, clr_req,
        input  req_ready, clr_busy, rf_wr_en, rf_wr_addr, rf_dat_in, grant_id
    );

    modport slave (
        input  req_valid, req_addr, req_data, clr_req,
        output req_ready, clr_busy, rf_wr_en, rf_wr_addr, rf_dat_in, grant_id
    );
endinterface

// File: rtl/rf_wr_sched.sv
// Round-robin scheduler for the register file's single write port, with a
// full-file clear sequencer that writes 0 to every address, one per cycle.
module rf_wr_sched #(
    parameter int pw   = 2,
    parameter int NREQ = 3,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    rf_wr_sched_if.slave  bus
);
    localparam int AW = pw + 1;
    localparam int GW = $clog2(NREQ);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [GW-1:0]   last, last_nxt;
    logic [GW-1:0]   win, idx;
    logic            found;
    logic [NREQ-1:0] ready;
    logic            wr_en_nxt, busy_nxt;
    logic [AW-1:0]   addr_nxt;
    logic [DW-1:0]   dat_nxt;
    logic [GW-1:0]   gid_nxt;

    // Search upward from the requester after the last winner, wrapping mod NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = GW'((int'(last) + k) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        wr_en_nxt = 1'b0;
        busy_nxt  = bus.clr_busy;
        addr_nxt  = bus.rf_wr_addr;
        dat_nxt   = bus.rf_dat_in;
        gid_nxt   = bus.grant_id;
        ready     = '0;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nxt = CLEAR;
                    busy_nxt  = 1'b1;
                    wr_en_nxt = 1'b1;
                    addr_nxt  = '0;
                    dat_nxt   = '0;
                    cnt_nxt   = AW'(1);
                end else if (found) begin
                    ready[win] = 1'b1;
                    wr_en_nxt  = 1'b1;
                    gid_nxt    = win;
                    last_nxt   = win;
                    for (int i = 0; i < NREQ; i++) begin
                        if (win == GW'(i)) begin
                            addr_nxt = bus.req_addr[i*AW +: AW];
                            dat_nxt  = bus.req_data[i*DW +: DW];
                        end
                    end
                end
            end
            CLEAR: begin
                // The counter wrapping back to 0 means the top address was just driven.
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    wr_en_nxt = 1'b1;
                    addr_nxt  = cnt;
                    dat_nxt   = '0;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready = ready & {NREQ{reset}};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the reset branch is asynchronous (active-low).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            last           <= GW'(NREQ - 1);
            bus.rf_wr_en   <= 1'b0;
            bus.rf_wr_addr <= '0;
            bus.rf_dat_in  <= '0;
            bus.grant_id   <= '0;
            bus.clr_busy   <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            last           <= last_nxt;
            bus.rf_wr_en   <= wr_en_nxt;
            bus.rf_wr_addr <= addr_nxt;
            bus.rf_dat_in  <= dat_nxt;
            bus.grant_id   <= gid_nxt;
            bus.clr_busy   <= busy_nxt;
        end
    end
endmodule
